// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: CPU state encoding and word byte-enable.
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC1 = 2'b01,
        EXEC2 = 2'b10,
        HALT  = 2'b11
    } state_t;

    localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mips_mem_req_mux.sv
// Combinational Avalon request selection from the CPU state.
// Ports:
//   s_st                    current CPU state
//   en                      request enable (no reset, no fault, not yet done this visit)
//   pc, daddr               instruction / data byte addresses
//   dread, dwrite           data access requests (write wins when both set)
//   dwdata, dbyteen         store data and byte enables
//   address, read, write,
//   writedata, byteenable   Avalon request outputs (zero when idle)
//   misalign_c              access in this state would be misaligned (ungated)
module mips_mem_req_mux
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  state_t              s_st,
    input  logic                en,
    input  logic [ADDR_W-1:0]   pc,
    input  logic [ADDR_W-1:0]   daddr,
    input  logic                dread,
    input  logic                dwrite,
    input  logic [DATA_W-1:0]   dwdata,
    input  logic [DATA_W/8-1:0] dbyteen,
    output logic [ADDR_W-1:0]   address,
    output logic                read,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    output logic [DATA_W/8-1:0] byteenable,
    output logic                misalign_c
);

    // Misaligned accesses never reach the bus; the top turns them into a fault.
    always_comb begin
        address    = '0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        byteenable = '0;
        misalign_c = 1'b0;
        case (s_st)
            FETCH: begin
                misalign_c = (pc[1:0] != 2'b00);
                if (en && !misalign_c) begin
                    read       = 1'b1;
                    address    = pc;
                    byteenable = BE_WORD;
                end
            end
            EXEC1: begin
                misalign_c = (dread || dwrite) && (daddr[1:0] != 2'b00)
                             && (dbyteen == BE_WORD);
                if (en && !misalign_c) begin
                    if (dwrite) begin
                        write      = 1'b1;
                        address    = daddr;
                        writedata  = dwdata;
                        byteenable = dbyteen;
                    end else if (dread) begin
                        read       = 1'b1;
                        address    = daddr;
                        byteenable = dbyteen;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_mem_bridge.sv
// Bridge between the MIPS CPU state machine and an Avalon-MM master port.
// Ports:
//   clk, rst                clock, asynchronous active-high reset
//   s                       CPU state (FETCH/EXEC1/EXEC2/HALT)
//   pc, daddr               instruction / data addresses
//   dread, dwrite, dwdata,
//   dbyteen                 data access request from EXEC1
//   address, read, write,
//   writedata, byteenable,
//   waitrequest, readdata   Avalon-MM master interface
//   instr, ldata            instruction and load data registers
//   stall                   request pending and slave waiting (to CPU waitrequest)
//   fault                   sticky misalignment flag (to CPU halt)
module mips_mem_bridge
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          s,
    input  logic [ADDR_W-1:0]   pc,
    input  logic [ADDR_W-1:0]   daddr,
    input  logic                dread,
    input  logic                dwrite,
    input  logic [DATA_W-1:0]   dwdata,
    input  logic [DATA_W/8-1:0] dbyteen,
    output logic [ADDR_W-1:0]   address,
    output logic                read,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    output logic [DATA_W/8-1:0] byteenable,
    input  logic                waitrequest,
    input  logic [DATA_W-1:0]   readdata,
    output logic [DATA_W-1:0]   instr,
    output logic [DATA_W-1:0]   ldata,
    output logic                stall,
    output logic                fault
);

    state_t              s_st;
    state_t              prev_s_q, prev_s_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [DATA_W-1:0]   ldata_q, ldata_d;
    logic                fault_q, fault_d;
    logic                done_q, done_d;
    logic                same_visit_c;
    logic                done_eff_c;
    logic                req_en_c;
    logic                misalign_c;
    logic                xfer_done_c;

    assign s_st = state_t'(s);

    // A stale done flag from the previous state visit must not block the new one.
    assign same_visit_c = (s_st == prev_s_q);
    assign done_eff_c   = done_q & same_visit_c;
    assign req_en_c     = !rst && !fault_q && !done_eff_c;

    mips_mem_req_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_req_mux (
        .s_st       (s_st),
        .en         (req_en_c),
        .pc         (pc),
        .daddr      (daddr),
        .dread      (dread),
        .dwrite     (dwrite),
        .dwdata     (dwdata),
        .dbyteen    (dbyteen),
        .address    (address),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .byteenable (byteenable),
        .misalign_c (misalign_c)
    );

    assign stall       = (read | write) & waitrequest;
    assign xfer_done_c = (read | write) & !waitrequest;

    assign instr = instr_q;
    assign ldata = ldata_q;
    assign fault = fault_q;

    // Next-state for capture registers and per-visit/sticky flags.
    always_comb begin
        instr_d  = instr_q;
        ldata_d  = ldata_q;
        fault_d  = fault_q;
        done_d   = done_q;
        prev_s_d = s_st;
        if (!same_visit_c) begin
            done_d = 1'b0;
        end
        if (xfer_done_c) begin
            done_d = 1'b1;
        end
        if (misalign_c) begin
            fault_d = 1'b1;
        end
        if (xfer_done_c && read) begin
            if (s_st == FETCH) begin
                instr_d = readdata;
            end else begin
                ldata_d = readdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q  <= '0;
            ldata_q  <= '0;
            fault_q  <= 1'b0;
            done_q   <= 1'b0;
            prev_s_q <= HALT;
        end else begin
            instr_q  <= instr_d;
            ldata_q  <= ldata_d;
            fault_q  <= fault_d;
            done_q   <= done_d;
            prev_s_q <= prev_s_d;
        end
    end

endmodule

// File: tb/tb_mips_mem_bridge.sv
// Scoreboard bench for mips_mem_bridge: the driver plays CPU state machine and
// Avalon slave, pushing the expected per-cycle bus view; a negedge monitor checks it.
module tb_mips_mem_bridge;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  s;
    logic [31:0] pc, daddr, dwdata, readdata;
    logic        dread, dwrite, waitrequest;
    logic [3:0]  dbyteen;
    logic [31:0] address, writedata, instr, ldata;
    logic        read, write, stall, fault;
    logic [3:0]  byteenable;

    always #5 clk = ~clk;

    mips_mem_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .s(s), .pc(pc), .daddr(daddr),
        .dread(dread), .dwrite(dwrite), .dwdata(dwdata), .dbyteen(dbyteen),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
        .instr(instr), .ldata(ldata), .stall(stall), .fault(fault)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        stall;
        logic [31:0] instr;
        logic [31:0] ldata;
        logic        fault;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_instr, m_ldata;
    logic        m_fault;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: one expected record per clock cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("read",       32'(read),       32'(e.rd));
            chk("write",      32'(write),      32'(e.wr));
            chk("address",    address,         e.addr);
            chk("byteenable", 32'(byteenable), 32'(e.be));
            if (e.wr) chk("writedata", writedata, e.wd);
            chk("stall",      32'(stall),      32'(e.stall));
            chk("instr",      instr,           e.instr);
            chk("ldata",      ldata,           e.ldata);
            chk("fault",      32'(fault),      32'(e.fault));
        end
    end

    function automatic exp_t idle_exp();
        exp_t e;
        e.rd = 1'b0; e.wr = 1'b0; e.addr = '0; e.be = '0; e.wd = '0;
        e.stall = 1'b0; e.instr = m_instr; e.ldata = m_ldata; e.fault = m_fault;
        return e;
    endfunction

    task automatic step(input exp_t e);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            waitrequest = 1'($urandom);
            readdata    = $urandom;
            step(idle_exp());
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        s = HALT;
        m_instr = '0; m_ldata = '0; m_fault = 1'b0;
        for (int i = 0; i < n; i++) step(idle_exp());
        rst = 1'b0;
    endtask

    // One FETCH visit: aligned word read with 'waits' wait states, then 'hold' extra cycles.
    task automatic visit_fetch(input logic [31:0] a, input int waits, input int hold,
                               input logic [31:0] word);
        exp_t e;
        s = FETCH; pc = a;
        daddr = $urandom; dread = 1'($urandom); dwrite = 1'($urandom);
        dwdata = $urandom; dbyteen = 4'($urandom);
        if (m_fault || a[1:0] != 2'b00) begin
            idle_cycles(1);
            if (a[1:0] != 2'b00) m_fault = 1'b1;
            idle_cycles(hold);
            return;
        end
        e = idle_exp();
        e.rd = 1'b1; e.addr = a; e.be = 4'hF; e.stall = 1'b1;
        for (int i = 0; i < waits; i++) begin
            waitrequest = 1'b1; readdata = $urandom;
            step(e);
        end
        waitrequest = 1'b0; readdata = word; e.stall = 1'b0;
        step(e);
        m_instr = word;
        idle_cycles(hold);
    endtask

    // One EXEC1 visit; op bit0 = load, bit1 = store (store wins if both).
    task automatic visit_exec1(input logic [1:0] op, input logic [31:0] a, input logic [3:0] be,
                               input logic [31:0] wd, input int waits, input int hold,
                               input logic [31:0] word);
        exp_t e;
        logic mis;
        s = EXEC1; daddr = a; dread = op[0]; dwrite = op[1];
        dwdata = wd; dbyteen = be; pc = $urandom;
        mis = (op != 2'b00) && (a[1:0] != 2'b00) && (be == 4'hF);
        if (op == 2'b00 || m_fault || mis) begin
            idle_cycles(1);
            if (mis) m_fault = 1'b1;
            idle_cycles(hold);
            return;
        end
        e = idle_exp();
        e.rd = !op[1]; e.wr = op[1]; e.addr = a; e.be = be; e.wd = wd; e.stall = 1'b1;
        for (int i = 0; i < waits; i++) begin
            waitrequest = 1'b1; readdata = $urandom;
            step(e);
        end
        waitrequest = 1'b0; readdata = word; e.stall = 1'b0;
        step(e);
        if (!op[1]) m_ldata = word;
        idle_cycles(hold);
    endtask

    task automatic visit_other(input logic [1:0] st);
        s = st;
        idle_cycles(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  be_tab [7];
        logic [31:0] ad;
        logic [3:0]  bev;
        be_tab = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
        rst = 1'b1; s = HALT; pc = '0; daddr = '0; dread = 1'b0; dwrite = 1'b0;
        dwdata = '0; dbyteen = '0; waitrequest = 1'b0; readdata = '0;
        m_instr = '0; m_ldata = '0; m_fault = 1'b0;
        @(posedge clk);
        #1;
        do_reset(2);

        // Directed: zero-wait fetch, 3-wait fetch, partial store, held load.
        visit_fetch(32'h100, 0, 0, 32'h8C220004);
        visit_exec1(2'b00, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0);
        visit_other(EXEC2);
        visit_fetch(32'h104, 3, 0, 32'h8C230008);
        visit_exec1(2'b10, 32'h2000, 4'b0011, 32'hDEADBEEF, 0, 0, 32'h0);
        visit_other(EXEC2);
        visit_fetch(32'h108, 0, 1, 32'h8C24000C);
        visit_exec1(2'b01, 32'h3000, 4'hF, 32'h0, 1, 2, 32'h12345678);
        visit_other(EXEC2);
        visit_exec1(2'b11, 32'h3004, 4'hF, 32'hCAFEF00D, 0, 1, 32'h0);
        visit_other(HALT);

        // Randomized instruction stream.
        for (int i = 0; i < 50; i++) begin
            visit_fetch($urandom & 32'hFFFF_FFFC, $urandom_range(0, 3),
                        ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom);
            bev = be_tab[$urandom_range(0, 6)];
            ad  = $urandom;
            if (bev == 4'hF) ad[1:0] = 2'b00;
            visit_exec1(2'($urandom), ad, bev, $urandom, $urandom_range(0, 3),
                        $urandom_range(0, 2), $urandom);
            visit_other(($urandom_range(0, 7) == 0) ? HALT : EXEC2);
        end

        // Reset asserted while a fetch is waiting.
        begin
            exp_t e;
            s = FETCH; pc = 32'h100; waitrequest = 1'b1;
            e = idle_exp();
            e.rd = 1'b1; e.addr = 32'h100; e.be = 4'hF; e.stall = 1'b1;
            for (int i = 0; i < 2; i++) begin
                readdata = $urandom;
                step(e);
            end
            rst = 1'b1;
            m_instr = '0; m_ldata = '0; m_fault = 1'b0;
            step(idle_exp());
            rst = 1'b0;
        end

        // Misaligned word load faults; everything afterwards is suppressed.
        visit_fetch(32'h200, 1, 0, 32'h0BADC0DE);
        visit_exec1(2'b01, 32'h2002, 4'hF, 32'h0, 0, 0, 32'h0);
        visit_other(EXEC2);
        visit_fetch(32'h204, 1, 0, 32'h11111111);
        visit_exec1(2'b10, 32'h2000, 4'hF, 32'h5555AAAA, 1, 0, 32'h0);
        do_reset(2);

        // Misaligned fetch faults; a following aligned fetch issues nothing.
        visit_fetch(32'h102, 0, 0, 32'h22222222);
        visit_fetch(32'h104, 2, 1, 32'h33333333);
        do_reset(1);
        visit_fetch(32'h104, 0, 0, 32'h44444444);
        visit_exec1(2'b01, 32'h1001, 4'h2, 32'h0, 2, 0, 32'h55555555);
        visit_other(EXEC2);

        @(negedge clk);
        @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
